// File: rtl/mem_sized_if.sv
// Request/response bundle between the load/store stage and mem_sized.
interface mem_sized_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              rw;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic              ready;
  logic              resp_valid;
  logic [31:0]       data_out;
  logic              err;

  modport master (
    output req, rw, size, sign_ext, addr, data_in,
    input  ready, resp_valid, data_out, err
  );

  modport slave (
    input  req, rw, size, sign_ext, addr, data_in,
    output ready, resp_valid, data_out, err
  );
endinterface

// File: rtl/mem_sized.sv
// Big-endian byte-addressable data memory with sized loads/stores, range/alignment
// checking and a fixed number of wait states per access.
module mem_sized #(
  parameter int unsigned MEM_DEPTH   = 262144,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic         clock,
  input  logic         reset,
  mem_sized_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              ready_q;
  logic [3:0]        cnt_q;
  logic              rw_q, sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [31:0]       data_out_q;
  logic              err_q;

  logic [7:0]        mem [MEM_DEPTH];

  logic              accept, enter_done, bad;
  logic              cur_rw, cur_sext;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_din, rdata;
  logic [ADDR_W:0]   last_addr;
  logic [IDX_W-1:0]  idx;
  int unsigned       nbytes;

  assign accept = bus.req && ready_q;

  // With zero wait states DONE is entered on the accept edge, before the latches load.
  always_comb begin
    cur_rw   = rw_q;
    cur_sext = sext_q;
    cur_size = size_q;
    cur_addr = addr_q;
    cur_din  = din_q;
    if (state_q == StIdle) begin
      cur_rw   = bus.rw;
      cur_sext = bus.sign_ext;
      cur_size = bus.size;
      cur_addr = bus.addr;
      cur_din  = bus.data_in;
    end
  end

  always_comb begin
    unique case (cur_size)
      2'b01:   nbytes = 2;
      2'b10:   nbytes = 4;
      default: nbytes = 1;
    endcase
    last_addr = {1'b0, cur_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    bad = (cur_size == 2'b11)
       || (cur_size == 2'b01 && cur_addr[0])
       || (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)
       || (last_addr > (ADDR_W+1)'(MEM_DEPTH - 1));
    idx = cur_addr[IDX_W-1:0];
  end

  always_comb begin
    rdata = '0;
    if (!bad) begin
      unique case (cur_size)
        2'b00: rdata = {{24{cur_sext & mem[idx][7]}}, mem[idx]};
        2'b01: rdata = {{16{cur_sext & mem[idx][7]}}, mem[idx], mem[idx + IDX_W'(1)]};
        2'b10: rdata = {mem[idx], mem[idx + IDX_W'(1)], mem[idx + IDX_W'(2)],
                        mem[idx + IDX_W'(3)]};
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (WAIT_STATES > 0) ? StWait : StDone;
      StWait: if (cnt_q == 4'(WAIT_STATES - 1)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    enter_done = (state_d == StDone) && (state_q != StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle);
      if (accept) begin
        cnt_q  <= '0;
        rw_q   <= bus.rw;
        sext_q <= bus.sign_ext;
        size_q <= bus.size;
        addr_q <= bus.addr;
        din_q  <= bus.data_in;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 4'd1;
      end
      err_q <= enter_done ? bad : 1'b0;
      if (enter_done) data_out_q <= (cur_rw && !bad) ? rdata : 32'h0;
    end
  end

  // Backing store is never cleared; only the addressed bytes are written.
  always_ff @(posedge clock) begin
    if (!reset && enter_done && !cur_rw && !bad) begin
      unique case (cur_size)
        2'b00: mem[idx] <= cur_din[7:0];
        2'b01: begin
          mem[idx]              <= cur_din[15:8];
          mem[idx + IDX_W'(1)]  <= cur_din[7:0];
        end
        2'b10: begin
          mem[idx]              <= cur_din[31:24];
          mem[idx + IDX_W'(1)]  <= cur_din[23:16];
          mem[idx + IDX_W'(2)]  <= cur_din[15:8];
          mem[idx + IDX_W'(3)]  <= cur_din[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.resp_valid = (state_q == StDone);
  assign bus.data_out   = data_out_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_mem_sized.sv
// Directed bench for mem_sized: vector table for data/err plus timing and reset sequences.
module tb_mem_sized;
  localparam int unsigned DEPTH = 262144;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_sized_if #(.ADDR_W(32)) bus ();
  mem_sized_if #(.ADDR_W(32)) bus0 ();

  mem_sized #(.MEM_DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  mem_sized #(.MEM_DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  typedef struct {
    string       name;
    logic        rw;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel0, input logic req, input logic rw, input logic [1:0] size,
                       input logic sext, input logic [31:0] addr, input logic [31:0] din);
    if (sel0) begin
      bus0.req = req; bus0.rw = rw; bus0.size = size; bus0.sign_ext = sext;
      bus0.addr = addr; bus0.data_in = din;
    end else begin
      bus.req = req; bus.rw = rw; bus.size = size; bus.sign_ext = sext;
      bus.addr = addr; bus.data_in = din;
    end
  endtask

  task automatic access(input bit sel0, input logic rw, input logic [1:0] size,
                        input logic sext, input logic [31:0] addr, input logic [31:0] din,
                        output logic [31:0] dout, output logic err, output int lat);
    int guard = 0;
    @(negedge clock);
    while (!(sel0 ? bus0.ready : bus.ready) && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    drive(sel0, 1'b1, rw, size, sext, addr, din);
    @(posedge clock);
    #1;
    drive(sel0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    lat = -1; dout = 32'h0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (sel0 ? bus0.resp_valid : bus.resp_valid) begin
        lat  = k;
        dout = sel0 ? bus0.data_out : bus.data_out;
        err  = sel0 ? bus0.err : bus.err;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          pulses;
    bit          saw;
    int          guard;

    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    vecs.push_back('{"sw_deadbeef", 1'b0, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0});
    vecs.push_back('{"lw_100",      1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{"lbu_101",     1'b1, 2'b00, 1'b0, 32'h101, 32'h0, 32'h000000AD, 1'b0});
    vecs.push_back('{"lb_100",      1'b1, 2'b00, 1'b1, 32'h100, 32'h0, 32'hFFFFFFDE, 1'b0});
    vecs.push_back('{"lh_102",      1'b1, 2'b01, 1'b1, 32'h102, 32'h0, 32'hFFFFBEEF, 1'b0});
    vecs.push_back('{"lhu_102",     1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 32'h0000BEEF, 1'b0});
    vecs.push_back('{"sb_103",      1'b0, 2'b00, 1'b0, 32'h103, 32'h12, 32'h0, 1'b0});
    vecs.push_back('{"lw_after_sb", 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBE12, 1'b0});
    vecs.push_back('{"sh_100",      1'b0, 2'b01, 1'b0, 32'h100, 32'h5566, 32'h0, 1'b0});
    vecs.push_back('{"lw_after_sh", 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'h5566BE12, 1'b0});
    vecs.push_back('{"lw_mis_102",  1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{"sh_mis_101",  1'b0, 2'b01, 1'b0, 32'h101, 32'h7777, 32'h0, 1'b1});
    vecs.push_back('{"lw_unchanged",1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'h5566BE12, 1'b0});
    vecs.push_back('{"lw_oor",      1'b1, 2'b10, 1'b0, DEPTH - 2, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{"sb_last",     1'b0, 2'b00, 1'b0, DEPTH - 1, 32'hA5, 32'h0, 1'b0});
    vecs.push_back('{"lb_last",     1'b1, 2'b00, 1'b1, DEPTH - 1, 32'h0, 32'hFFFFFFA5, 1'b0});
    vecs.push_back('{"lbu_last",    1'b1, 2'b00, 1'b0, DEPTH - 1, 32'h0, 32'h000000A5, 1'b0});
    vecs.push_back('{"size_rsvd",   1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{"sw_top",      1'b0, 2'b10, 1'b0, DEPTH - 4, 32'h11223344, 32'h0, 1'b0});
    vecs.push_back('{"lw_top",      1'b1, 2'b10, 1'b0, DEPTH - 4, 32'h0, 32'h11223344, 1'b0});
    vecs.push_back('{"lw_nowrap",   1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1});

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", {31'b0, bus.ready}, 32'h0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_err", {31'b0, bus.err}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", {31'b0, bus.ready}, 32'h1);

    foreach (vecs[i]) begin
      access(1'b0, vecs[i].rw, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].din, d, e, lat);
      check({vecs[i].name, "_data"}, d, vecs[i].exp_d);
      check({vecs[i].name, "_err"}, {31'b0, e}, {31'b0, vecs[i].exp_e});
      check({vecs[i].name, "_lat"}, lat, 3);
    end

    // Zero wait states
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'hA1B2C3D4, d, e, lat);
    check("ws0_sw_lat", lat, 1);
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, d, e, lat);
    check("ws0_lw_lat", lat, 1);
    check("ws0_lw_data", d, 32'hA1B2C3D4);

    // Cycle-by-cycle handshake timing after accept
    @(negedge clock);
    guard = 0;
    while (!bus.ready && guard < 20) begin @(negedge clock); guard++; end
    drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check($sformatf("tim_ready_c%0d", k), {31'b0, bus.ready}, {31'b0, k == 4});
      check($sformatf("tim_resp_c%0d", k), {31'b0, bus.resp_valid}, {31'b0, k == 3});
    end

    // req held high: one access per four cycles
    drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (bus.resp_valid) pulses++;
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("held_req_pulses", pulses, 4);

    // Reset during WAIT aborts the store
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h01020304, d, e, lat);
    check("sw_old_err", {31'b0, e}, 32'h0);
    @(negedge clock);
    guard = 0;
    while (!bus.ready && guard < 20) begin @(negedge clock); guard++; end
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D);
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    saw = bus.resp_valid;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bus.resp_valid) saw = 1'b1;
      check($sformatf("ready_in_reset_%0d", k), {31'b0, bus.ready}, 32'h0);
    end
    reset = 1'b0;
    @(negedge clock);
    if (bus.resp_valid) saw = 1'b1;
    check("ready_post_reset", {31'b0, bus.ready}, 32'h1);
    check("no_resp_on_abort", {31'b0, saw}, 32'h0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0, d, e, lat);
    check("lw_after_abort", d, 32'h01020304);
    check("lw_after_abort_err", {31'b0, e}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
